// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle: ID/EX hazard inputs toward the sequencer and the
// pipeline-register enables / bubbles coming back from it.
interface pipeline_hazard_ctrl_if;
  localparam int unsigned REG_W = 5;

  logic [REG_W-1:0] id_rn;
  logic [REG_W-1:0] id_rm;
  logic             id_use_rn;
  logic             id_use_rm;
  logic             ex_memread;
  logic [REG_W-1:0] ex_rd;
  logic             ex_mul;
  logic             br_taken;

  logic pc_write;
  logic ifid_write;
  logic ifid_flush;
  logic idex_write;
  logic idex_bubble;
  logic exmem_bubble;
  logic mul_busy;

  modport master (
    output id_rn, id_rm, id_use_rn, id_use_rm, ex_memread, ex_rd, ex_mul, br_taken,
    input  pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble, mul_busy
  );

  modport slave (
    input  id_rn, id_rm, id_use_rn, id_use_rm, ex_memread, ex_rd, ex_mul, br_taken,
    output pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble, mul_busy
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stall, multi-cycle MUL hold, taken-branch squash.
// Optional PIPE_CTRL_PERF_EN adds a saturating stall_cnt port counting cycles with pc_write low.
module pipeline_hazard_ctrl #(
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  pipeline_hazard_ctrl_if.slave   hz
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]             stall_cnt
`endif
);

  localparam int unsigned REG_W  = 5;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned PERF_W = 32;
  localparam logic [REG_W-1:0] XZR = REG_W'(31);
  localparam bit MUL_STALL_EN = (MUL_CYCLES > 1);
  // MUL_CYCLES==1 never loads the counter; guard keeps the subtraction from wrapping.
  localparam logic [CNT_W-1:0] CNT_LOAD = MUL_STALL_EN ? CNT_W'(MUL_CYCLES - 2) : CNT_W'(0);

  typedef enum logic {
    RUN  = 1'b0,
    MULW = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic load_use;
  logic mul_start;
  logic pc_write_c;
  logic ifid_write_c;
  logic ifid_flush_c;
  logic idex_write_c;
  logic idex_bubble_c;
  logic exmem_bubble_c;
  logic mul_busy_c;

  // XZR as a load destination never produces a value anyone waits for.
  always_comb begin
    load_use = hz.ex_memread && (hz.ex_rd != XZR) &&
               ((hz.id_use_rn && (hz.id_rn == hz.ex_rd)) ||
                (hz.id_use_rm && (hz.id_rm == hz.ex_rd)));
    mul_start = MUL_STALL_EN && hz.ex_mul;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    pc_write_c     = 1'b1;
    ifid_write_c   = 1'b1;
    ifid_flush_c   = 1'b0;
    idex_write_c   = 1'b1;
    idex_bubble_c  = 1'b0;
    exmem_bubble_c = 1'b0;
    mul_busy_c     = 1'b0;

    if (reset) begin
      // Hold fetch and drain every stage with NOPs while reset is asserted.
      state_nxt      = RUN;
      cnt_nxt        = '0;
      pc_write_c     = 1'b0;
      ifid_write_c   = 1'b0;
      ifid_flush_c   = 1'b1;
      idex_write_c   = 1'b1;
      idex_bubble_c  = 1'b1;
      exmem_bubble_c = 1'b1;
      mul_busy_c     = 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (hz.br_taken) begin
            // Squash the two wrong-path instructions in IF/ID and ID/EX.
            ifid_flush_c  = 1'b1;
            idex_bubble_c = 1'b1;
          end else if (mul_start) begin
            state_nxt      = MULW;
            cnt_nxt        = CNT_LOAD;
            pc_write_c     = 1'b0;
            ifid_write_c   = 1'b0;
            idex_write_c   = 1'b0;
            exmem_bubble_c = 1'b1;
            mul_busy_c     = 1'b1;
          end else if (load_use) begin
            pc_write_c    = 1'b0;
            ifid_write_c  = 1'b0;
            idex_bubble_c = 1'b1;
          end
        end

        MULW: begin
          // MUL owns EX here, so branch and load-use inputs cannot be valid.
          pc_write_c     = 1'b0;
          ifid_write_c   = 1'b0;
          idex_write_c   = 1'b0;
          exmem_bubble_c = 1'b1;
          mul_busy_c     = 1'b1;
          if (cnt == '0) begin
            state_nxt = RUN;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end

        default: begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    hz.pc_write     = pc_write_c;
    hz.ifid_write   = ifid_write_c;
    hz.ifid_flush   = ifid_flush_c;
    hz.idex_write   = idex_write_c;
    hz.idex_bubble  = idex_bubble_c;
    hz.exmem_bubble = exmem_bubble_c;
    hz.mul_busy     = mul_busy_c;
  end

`ifdef PIPE_CTRL_PERF_EN
  // Saturating count of cycles in which fetch was held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (!pc_write_c && (stall_cnt != {PERF_W{1'b1}})) begin
      stall_cnt <= stall_cnt + PERF_W'(1);
    end
  end
`endif

endmodule
